// File: rtl/compressed_act_fetch.sv
// Fetches one pixel's row range from the cumulative index table and streams its two mask-word
// addresses followed by its compressed activation-row addresses on a valid/ready port.
module compressed_act_fetch #(
    parameter int MEM_BW           = 128,
    parameter int ADDR_WIDTH_ACT   = 14,
    parameter int ADDR_WIDTH_MASKS = 11
) (
    input  logic                        clk,
    input  logic                        arst_n_in,
    input  logic                        start,
    input  logic [ADDR_WIDTH_MASKS-2:0] pixel_index,
    output logic                        busy,
    output logic                        idx_re,
    output logic [ADDR_WIDTH_MASKS-2:0] idx_addr,
    input  logic [31:0]                 idx_rdata,
    output logic                        out_valid,
    input  logic                        out_ready,
    output logic                        out_is_mask,
    output logic [ADDR_WIDTH_ACT-1:0]   out_addr,
    output logic [ADDR_WIDTH_ACT-1:0]   row_count,
    output logic                        done,
    output logic                        err
);

    localparam int PIX_W    = ADDR_WIDTH_MASKS - 1;
    localparam int WORDS_PX = 256 / MEM_BW;

    typedef enum logic [2:0] {
        StIdle, StRdPrev, StRdCur, StCapture, StMask0, StMask1, StRows, StFinish
    } state_t;

    state_t                    r_state, w_state_next;
    logic [PIX_W-1:0]          r_p;
    logic [31:0]               r_prev;
    logic [ADDR_WIDTH_ACT-1:0] r_ptr;
    logic [ADDR_WIDTH_ACT-1:0] r_left;
    logic [ADDR_WIDTH_ACT-1:0] r_row_count;
    logic                      r_err;
    logic [ADDR_WIDTH_ACT-1:0] w_mask_base;
    logic [ADDR_WIDTH_ACT-1:0] w_rows;

    assign w_mask_base = ADDR_WIDTH_ACT'(r_p) * ADDR_WIDTH_ACT'(WORDS_PX);
    // 32-bit difference, truncated to the activation address width
    assign w_rows      = ADDR_WIDTH_ACT'(idx_rdata - r_prev);
    assign row_count   = r_row_count;
    assign err         = r_err;

    always_comb begin
        w_state_next = r_state;
        busy         = (r_state != StIdle);
        idx_re       = 1'b0;
        idx_addr     = '0;
        out_valid    = 1'b0;
        out_is_mask  = 1'b0;
        out_addr     = '0;
        done         = 1'b0;
        unique case (r_state)
            StIdle: begin
                if (start) w_state_next = (pixel_index != '0) ? StRdPrev : StRdCur;
            end
            StRdPrev: begin
                idx_re       = 1'b1;
                idx_addr     = r_p - PIX_W'(1);
                w_state_next = StRdCur;
            end
            StRdCur: begin
                idx_re       = 1'b1;
                idx_addr     = r_p;
                w_state_next = StCapture;
            end
            StCapture: w_state_next = StMask0;
            StMask0: begin
                out_valid   = 1'b1;
                out_is_mask = 1'b1;
                out_addr    = w_mask_base;
                if (out_ready) w_state_next = StMask1;
            end
            StMask1: begin
                out_valid   = 1'b1;
                out_is_mask = 1'b1;
                out_addr    = w_mask_base + ADDR_WIDTH_ACT'(1);
                if (out_ready) w_state_next = (r_row_count != '0) ? StRows : StFinish;
            end
            StRows: begin
                out_valid = 1'b1;
                out_addr  = r_ptr;
                if (out_ready && r_left == ADDR_WIDTH_ACT'(1)) w_state_next = StFinish;
            end
            StFinish: begin
                done         = 1'b1;
                w_state_next = StIdle;
            end
            default: w_state_next = StIdle;
        endcase
    end

    always_ff @(posedge clk or negedge arst_n_in) begin
        if (!arst_n_in) begin
            r_state     <= StIdle;
            r_p         <= '0;
            r_prev      <= '0;
            r_ptr       <= '0;
            r_left      <= '0;
            r_row_count <= '0;
            r_err       <= 1'b0;
        end else begin
            r_state <= w_state_next;
            case (r_state)
                StIdle: begin
                    if (start) begin
                        r_p    <= pixel_index;
                        r_err  <= 1'b0;
                        r_prev <= '0;
                    end
                end
                StRdCur: begin
                    // Pixel 0 has no predecessor entry; prev stays at the zero set on start
                    if (r_p != '0) r_prev <= idx_rdata;
                end
                StCapture: begin
                    r_ptr <= r_prev[ADDR_WIDTH_ACT-1:0];
                    if (idx_rdata < r_prev) begin
                        r_row_count <= '0;
                        r_left      <= '0;
                        r_err       <= 1'b1;
                    end else begin
                        r_row_count <= w_rows;
                        r_left      <= w_rows;
                    end
                end
                StRows: begin
                    if (out_ready) begin
                        r_ptr  <= r_ptr + ADDR_WIDTH_ACT'(1);
                        r_left <= r_left - ADDR_WIDTH_ACT'(1);
                    end
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_compressed_act_fetch.sv
// Randomised scoreboard bench for compressed_act_fetch: an index-table model, a ready driver,
// and independent monitors for the read port and the address stream.
module tb_compressed_act_fetch;

    logic        clk = 1'b0;
    logic        arst_n_in = 1'b0;
    logic        start = 1'b0;
    logic [9:0]  pixel_index = '0;
    logic        busy;
    logic        idx_re;
    logic [9:0]  idx_addr;
    logic [31:0] idx_rdata = '0;
    logic        out_valid;
    logic        out_ready = 1'b0;
    logic        out_is_mask;
    logic [13:0] out_addr;
    logic [13:0] row_count;
    logic        done;
    logic        err;

    compressed_act_fetch #(
        .MEM_BW          (128),
        .ADDR_WIDTH_ACT  (14),
        .ADDR_WIDTH_MASKS(11)
    ) dut (
        .clk        (clk),
        .arst_n_in  (arst_n_in),
        .start      (start),
        .pixel_index(pixel_index),
        .busy       (busy),
        .idx_re     (idx_re),
        .idx_addr   (idx_addr),
        .idx_rdata  (idx_rdata),
        .out_valid  (out_valid),
        .out_ready  (out_ready),
        .out_is_mask(out_is_mask),
        .out_addr   (out_addr),
        .row_count  (row_count),
        .done       (done),
        .err        (err)
    );

    always #5 clk = ~clk;

    int          total = 0;
    int          bad = 0;
    int          ready_mode = 0;
    int          rd_seen = 0;
    logic [31:0] mem [0:1023];
    logic [14:0] exp_q[$];
    logic [9:0]  rd_q[$];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    // Index table: data valid one cycle after the read enable
    always @(posedge clk) begin
        if (idx_re) idx_rdata <= mem[idx_addr];
    end

    initial begin
        forever begin
            @(posedge clk);
            #1;
            case (ready_mode)
                0:       out_ready = 1'b1;
                1:       out_ready = ~out_ready;
                default: out_ready = 1'($urandom_range(0, 1));
            endcase
        end
    end

    // Read-port monitor
    initial begin
        forever begin
            @(negedge clk);
            if (arst_n_in && idx_re) begin
                rd_seen++;
                if (rd_q.size() == 0) begin
                    total++;
                    bad++;
                    $display("FAIL unexpected idx read: addr 0x%0h, none expected", idx_addr);
                end else begin
                    chk("idx_addr", 32'(idx_addr), 32'(rd_q.pop_front()));
                end
            end
        end
    end

    // Stream monitor: pops expected addresses on every transfer, checks stability while stalled
    initial begin
        logic        hold_v;
        logic [14:0] hold_d;
        hold_v = 1'b0;
        hold_d = '0;
        forever begin
            @(negedge clk);
            if (!arst_n_in) begin
                hold_v = 1'b0;
            end else begin
                if (hold_v) begin
                    chk("stall valid", 32'(out_valid), 32'd1);
                    chk("stall data", 32'({out_is_mask, out_addr}), 32'(hold_d));
                end
                if (out_valid && out_ready) begin
                    if (exp_q.size() == 0) begin
                        total++;
                        bad++;
                        $display("FAIL unexpected transfer: mask=%0d addr 0x%0h, none expected",
                                 out_is_mask, out_addr);
                    end else begin
                        chk("transfer", 32'({out_is_mask, out_addr}), 32'(exp_q.pop_front()));
                    end
                end
                hold_v = out_valid && !out_ready;
                hold_d = {out_is_mask, out_addr};
            end
        end
    end

    // Reference: rows of pixel p are prev..cur-1 where prev is entry p-1 (or 0) and cur is entry p
    task automatic expect_pixel(input int p, output int rc, output bit e);
        logic [31:0] prev;
        logic [31:0] cur;
        prev = (p == 0) ? 32'd0 : mem[p-1];
        cur  = mem[p];
        if (cur < prev) begin
            rc = 0;
            e  = 1'b1;
        end else begin
            rc = int'((cur - prev) % 32'd16384);
            e  = 1'b0;
        end
        if (p != 0) rd_q.push_back(10'(p - 1));
        rd_q.push_back(10'(p));
        exp_q.push_back({1'b1, 14'(2 * p)});
        exp_q.push_back({1'b1, 14'(2 * p + 1)});
        for (int i = 0; i < rc; i++) exp_q.push_back({1'b0, 14'(prev + 32'(i))});
    endtask

    task automatic do_reset(input string tag);
        @(negedge clk);
        arst_n_in = 1'b0;
        #1;
        chk({tag, " rst out_valid"}, 32'(out_valid), 32'd0);
        chk({tag, " rst busy"}, 32'(busy), 32'd0);
        chk({tag, " rst out_addr"}, 32'(out_addr), 32'd0);
        chk({tag, " rst idx_re"}, 32'(idx_re), 32'd0);
        chk({tag, " rst done"}, 32'(done), 32'd0);
        chk({tag, " rst row_count"}, 32'(row_count), 32'd0);
        chk({tag, " rst err"}, 32'(err), 32'd0);
        repeat (2) @(negedge clk);
        exp_q.delete();
        rd_q.delete();
        arst_n_in = 1'b1;
    endtask

    task automatic issue_start(input int p);
        @(posedge clk);
        #1;
        start       = 1'b1;
        pixel_index = 10'(p);
        @(posedge clk);
        #1;
        start = 1'b0;
    endtask

    task automatic run_pixel(input int p, input int mode, input bit chk_lat, input bit inject);
        int rc;
        bit e;
        int lat;
        expect_pixel(p, rc, e);
        ready_mode = mode;
        issue_start(p);
        lat = -1;
        for (int cyc = 1; cyc <= 2000; cyc++) begin
            @(negedge clk);
            if (cyc == 1) chk("busy after start", 32'(busy), 32'd1);
            if (inject && cyc == 2) begin
                start       = 1'b1;
                pixel_index = 10'(p ^ 1);
            end
            if (inject && cyc == 3) begin
                start       = 1'b0;
                pixel_index = 10'(p);
            end
            if (done) begin
                lat = cyc;
                break;
            end
        end
        chk("done seen", 32'(lat > 0), 32'd1);
        if (lat < 0) begin
            do_reset("timeout");
        end else begin
            if (chk_lat) chk("done latency", 32'(lat), 32'((p == 0) ? 5 + rc : 6 + rc));
            chk("row_count", 32'(row_count), 32'(rc));
            chk("err", 32'(err), 32'(e));
            chk("stream drained", 32'(exp_q.size()), 32'd0);
            chk("reads drained", 32'(rd_q.size()), 32'd0);
            @(negedge clk);
            chk("done pulse width", 32'(done), 32'd0);
            chk("idle after done", 32'(busy), 32'd0);
        end
    endtask

    initial begin
        int rc;
        bit e;
        int p;
        for (int i = 0; i < 1024; i++) mem[i] = '0;

        do_reset("init");
        repeat (10) @(negedge clk);
        chk("idle reads", 32'(rd_seen), 32'd0);
        chk("idle busy", 32'(busy), 32'd0);
        chk("idle valid", 32'(out_valid), 32'd0);

        mem[0] = 32'd3;
        run_pixel(0, 0, 1'b1, 1'b0);

        mem[4] = 32'd40;
        mem[5] = 32'd57;
        run_pixel(5, 0, 1'b1, 1'b0);

        mem[6] = 32'd20;
        mem[7] = 32'd20;
        run_pixel(7, 0, 1'b1, 1'b0);

        run_pixel(5, 1, 1'b0, 1'b0);

        // Decreasing table entries, plus a start pulse while busy that must be ignored
        mem[2] = 32'd9;
        mem[3] = 32'd4;
        run_pixel(3, 0, 1'b1, 1'b1);

        // Abort in the middle of the row stream
        expect_pixel(5, rc, e);
        ready_mode = 0;
        issue_start(5);
        repeat (9) @(negedge clk);
        chk("in rows before abort", 32'({out_valid, out_is_mask}), 32'd2);
        do_reset("abort");
        run_pixel(5, 0, 1'b1, 1'b0);

        // Row pointer wraps past the top of activation memory
        mem[8] = 32'd16380;
        mem[9] = 32'd16390;
        run_pixel(9, 2, 1'b0, 1'b0);

        for (int n = 0; n < 20; n++) begin
            p = int'($urandom_range(0, 1023));
            if (p == 0) begin
                mem[0] = 32'($urandom_range(0, 25));
            end else begin
                mem[p-1] = 32'($urandom_range(0, 70000));
                if ($urandom_range(0, 7) == 0 && mem[p-1] != 0) mem[p] = mem[p-1] - 32'd1;
                else mem[p] = mem[p-1] + 32'($urandom_range(0, 25));
            end
            run_pixel(p, 2, 1'b0, 1'b0);
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
